pwm_duty_capture: RTL and testbench
===================================

// Module: pwm_duty_capture
// PURPOSE
//  Receive-side counterpart of the LED PWM generator: samples an external PWM line and
//  measures its period and high time in CLOCK_50 cycles. Publishes one measurement per
//  complete period, flags a stuck (edge-less) line, and feeds duty readback or loopback
//  checks of the breathing-LED output. Sits beside the PWM generator in the top level.
// PARAMETERS
//  COUNT_WIDTH  16  width of period/high counters and outputs; max measurable = 2^W-1
//  SYNC_STAGES  2   flip-flops in the PWM_IN synchronizer (>=2)
// PORTS
//  CLOCK_50   in   1       system clock; all logic on rising edge
//  RESET      in   1       asynchronous, active-high reset
//  ENABLE     in   1       1 = measure; 0 = force IDLE, drop LOCKED
//  PWM_IN     in   1       asynchronous PWM line
//  LEVEL      out  1       synchronized PWM_IN
//  HIGH_TIME  out  W       clocks high in last complete period
//  PERIOD     out  W       clocks between last two rising edges
//  VALID      out  1       1-cycle strobe: HIGH_TIME/PERIOD updated this cycle
//  LOCKED     out  1       level: outputs hold a current measurement
//  STUCK      out  1       level: no edge for 2^W-1 clocks
// BEHAVIOUR
//  - Reset: all outputs 0, counter 0, state IDLE, edge detector primed with level 0.
//  - Edge detect on synced level s vs s_d: rise = s&~s_d, fall = ~s&s_d. Detection lag is
//    SYNC_STAGES+1 clocks from PWM_IN; the lag is identical for both edges, so it cancels.
//  - Counter cnt: rise cycle loads 1; otherwise +1 every cycle in HIGH/LOW; holds at 2^W-1.
//  - States:
//    IDLE: cnt held 0; rise -> HIGH (first rise produces no VALID).
//    HIGH: fall -> hi_lat<=cnt, LOW. cnt==MAX with no edge -> TIMEOUT.
//    LOW: rise -> HIGH_TIME<=hi_lat, PERIOD<=cnt, VALID=1 next cycle, LOCKED<=1, reload.
//         cnt==MAX with no edge -> TIMEOUT.
//    TIMEOUT (1 cycle): STUCK<=1, LOCKED<=0, HIGH_TIME/PERIOD hold, -> IDLE.
//  - Example: high 3 / low 5 -> HIGH_TIME=3, PERIOD=8 (cnt sampled before reload).
//  - VALID registered: asserted the cycle after the rise that closes the period.
//  - STUCK clears on the next detected rise or fall; LOCKED rises again only after a
//    full period is measured.
//  - Edge and cnt==MAX in the same cycle: the edge wins; a measurement of MAX is legal.
//  - A rise seen in HIGH (missed fall) is impossible: the single synced bit alternates.
//  - 1-clock pulses are measured as 1; no glitch filter.
//  - ENABLE=0: next cycle state IDLE, LOCKED=0, VALID=0, STUCK=0; HIGH_TIME/PERIOD hold;
//    LEVEL keeps tracking. Re-enable: wait for a rise, then a full period.
//  - RESET mid-period: immediate clear; no partial measurement is published.
// STRUCTURE
//  - pwm_defs.vh (shared with the PWM generator): default PWM resolution (8 bit, 256
//    clocks/period) so loopback expectations agree. State codes stay local to this module.
//  - One sub-module: pwm_input_sync (SYNC_STAGES synchronizer, s_d register, rise/fall
//    outputs, LEVEL). FSM, counter and output registers stay in pwm_duty_capture.
// TESTING
//  - Reset: RESET=1 mid-stream -> all outputs 0 within 1 clock; no VALID until 2 rises.
//  - Square wave 3 high/5 low, W=16 -> from 2nd rise on, VALID every 8 clks, HIGH_TIME=3,
//    PERIOD=8, LOCKED=1.
//  - Loopback from 8-bit generator, compare 64 -> PERIOD=256, HIGH_TIME=192 every
//    period; compare sweep tracked each period.
//  - PWM_IN held 1 after a rise, W=8 -> STUCK=1, LOCKED=0 after 255 clks; next fall clears STUCK.
//  - Edge coinciding with cnt==MAX (W=8, low 255-high) -> VALID with PERIOD=255, no STUCK.
//  - ENABLE dropped mid-HIGH, restored -> no VALID for the broken period; first VALID
//    only after one complete period following re-enable.

Source files
------------

// File: rtl/pwm_duty_capture_pkg.sv
// ============================================================================
// Module : pwm_duty_capture_pkg
// Brief  : Shared PWM resolution defaults and edge-detect record type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pwm_duty_capture_pkg;

    // Default generator resolution, kept identical to the LED PWM generator
    localparam int PWM_RES_BITS    = 8;
    localparam int PWM_PERIOD_CLKS = 1 << PWM_RES_BITS;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

endpackage

`default_nettype wire

// File: rtl/pwm_duty_capture_input_sync.sv
// ============================================================================
// Module : pwm_input_sync
// Brief  : Multi-stage synchronizer for PWM_IN with rise/fall detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_input_sync
    import pwm_duty_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_pwm,
    output logic  o_level,
    output edge_t o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pwm};
            r_level_d <= w_level;
        end
    end

    assign o_level     = w_level;
    assign o_edge.rise = w_level & ~r_level_d;
    assign o_edge.fall = ~w_level & r_level_d;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_capture.sv
// ============================================================================
// Module : pwm_duty_capture
// Brief  : Measures period and high time of an external PWM line in clocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_duty_capture
    import pwm_duty_capture_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic                   PWM_IN,
    output logic                   LEVEL,
    output logic [COUNT_WIDTH-1:0] HIGH_TIME,
    output logic [COUNT_WIDTH-1:0] PERIOD,
    output logic                   VALID,
    output logic                   LOCKED,
    output logic                   STUCK
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_HIGH    = 2'd1;
    localparam logic [1:0] c_ST_LOW     = 2'd2;
    localparam logic [1:0] c_ST_TIMEOUT = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE = COUNT_WIDTH'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_next;
    logic [COUNT_WIDTH-1:0] r_hi_lat;
    logic                   w_publish;
    logic                   w_latch_hi;
    logic                   w_timeout;
    logic                   w_cnt_max;
    edge_t                  w_edge;

    pwm_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .i_pwm   (PWM_IN),
        .o_level (LEVEL),
        .o_edge  (w_edge)
    );

    assign w_cnt_max = (r_cnt == c_CNT_MAX);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Edges take priority over the saturation check, so a period of exactly MAX is legal
    always_comb begin
        w_state_next = r_state;
        if (!ENABLE) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    if (w_edge.rise) w_state_next = c_ST_HIGH;
                c_ST_HIGH: begin
                    if (w_edge.fall)    w_state_next = c_ST_LOW;
                    else if (w_cnt_max) w_state_next = c_ST_TIMEOUT;
                end
                c_ST_LOW: begin
                    if (w_edge.rise)    w_state_next = c_ST_HIGH;
                    else if (w_cnt_max) w_state_next = c_ST_TIMEOUT;
                end
                c_ST_TIMEOUT: w_state_next = w_edge.rise ? c_ST_HIGH : c_ST_IDLE;
                default:      w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_publish  = ENABLE && (r_state == c_ST_LOW)  && w_edge.rise;
        w_latch_hi = ENABLE && (r_state == c_ST_HIGH) && w_edge.fall;
        w_timeout  = ENABLE && (r_state == c_ST_TIMEOUT);
        w_cnt_next = r_cnt;
        if (!ENABLE) begin
            w_cnt_next = '0;
        end else if (w_edge.rise) begin
            w_cnt_next = c_CNT_ONE;
        end else if ((r_state == c_ST_HIGH) || (r_state == c_ST_LOW)) begin
            if (!w_cnt_max) w_cnt_next = r_cnt + c_CNT_ONE;
        end else begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_hi_lat  <= '0;
            HIGH_TIME <= '0;
            PERIOD    <= '0;
            VALID     <= 1'b0;
            LOCKED    <= 1'b0;
            STUCK     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            VALID <= w_publish;
            if (w_latch_hi) r_hi_lat <= r_cnt;
            if (w_publish) begin
                HIGH_TIME <= r_hi_lat;
                PERIOD    <= r_cnt;
            end
            if (!ENABLE || w_timeout) LOCKED <= 1'b0;
            else if (w_publish)       LOCKED <= 1'b1;
            // Any edge proves the line is alive, even in the timeout cycle itself
            if (!ENABLE || w_edge.rise || w_edge.fall) STUCK <= 1'b0;
            else if (w_timeout)                        STUCK <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_capture.sv
// ============================================================================
// Module : tb_pwm_duty_capture
// Brief  : Directed self-checking bench for pwm_duty_capture (W=16 and W=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_duty_capture;
    import pwm_duty_capture_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en16, pwm16, en8, pwm8;
    logic        lvl16, valid16, locked16, stuck16;
    logic [15:0] ht16, per16;
    logic        lvl8, valid8, locked8, stuck8;
    logic [7:0]  ht8, per8;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          v16_n = 0, v16_gap = 0, v16_last = 0;
    logic [15:0] v16_ht = '0, v16_per = '0;
    int          v8_n = 0;
    logic [7:0]  v8_ht = '0, v8_per = '0;

    pwm_duty_capture #(.COUNT_WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .CLOCK_50 (clk),   .RESET  (rst),      .ENABLE (en16),    .PWM_IN (pwm16),
        .LEVEL    (lvl16), .HIGH_TIME (ht16),  .PERIOD (per16),   .VALID  (valid16),
        .LOCKED   (locked16), .STUCK (stuck16)
    );

    pwm_duty_capture #(.COUNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .CLOCK_50 (clk),   .RESET  (rst),      .ENABLE (en8),     .PWM_IN (pwm8),
        .LEVEL    (lvl8),  .HIGH_TIME (ht8),   .PERIOD (per8),    .VALID  (valid8),
        .LOCKED   (locked8), .STUCK (stuck8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every published measurement and the spacing between them
    always @(negedge clk) begin
        if (valid16) begin
            v16_n++;
            v16_ht   = ht16;
            v16_per  = per16;
            v16_gap  = cyc - v16_last;
            v16_last = cyc;
        end
        if (valid8) begin
            v8_n++;
            v8_ht  = ht8;
            v8_per = per8;
        end
    end

    task automatic pulse16(input logic lv, input int n);
        pwm16 = lv;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse8(input logic lv, input int n);
        pwm8 = lv;
        repeat (n) @(negedge clk);
    endtask

    task automatic gen16(input int cmp, input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < PWM_PERIOD_CLKS; i++) begin
                pwm16 = (i >= cmp);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en16 = 1'b1; en8 = 1'b1; pwm16 = 1'b0; pwm8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (lvl16 !== 1'b0)    begin errors++; $display("FAIL reset_level: got %0b want 0", lvl16); end
        checks++; if (ht16 !== 16'd0)    begin errors++; $display("FAIL reset_high_time: got %0d want 0", ht16); end
        checks++; if (per16 !== 16'd0)   begin errors++; $display("FAIL reset_period: got %0d want 0", per16); end
        checks++; if (valid16 !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %0b want 0", valid16); end
        checks++; if (locked16 !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked16); end
        checks++; if (stuck16 !== 1'b0)  begin errors++; $display("FAIL reset_stuck: got %0b want 0", stuck16); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_square();
        int n0;
        n0 = v16_n;
        for (int p = 0; p < 7; p++) begin
            pulse16(1'b1, 3);
            pulse16(1'b0, 5);
        end
        checks++; if (v16_n - n0 !== 6)  begin errors++; $display("FAIL square_count: got %0d want 6", v16_n - n0); end
        checks++; if (v16_ht !== 16'd3)  begin errors++; $display("FAIL square_high_time: got %0d want 3", v16_ht); end
        checks++; if (v16_per !== 16'd8) begin errors++; $display("FAIL square_period: got %0d want 8", v16_per); end
        checks++; if (v16_gap !== 8)     begin errors++; $display("FAIL square_valid_gap: got %0d want 8", v16_gap); end
        checks++; if (locked16 !== 1'b1) begin errors++; $display("FAIL square_locked: got %0b want 1", locked16); end
        checks++; if (stuck16 !== 1'b0)  begin errors++; $display("FAIL square_stuck: got %0b want 0", stuck16); end
    endtask

    task automatic test_midstream_reset();
        int n1;
        pulse16(1'b1, 2);
        rst = 1'b1; pwm16 = 1'b0;
        #1;
        checks++; if (locked16 !== 1'b0) begin errors++; $display("FAIL midreset_locked: got %0b want 0", locked16); end
        checks++; if (per16 !== 16'd0)   begin errors++; $display("FAIL midreset_period: got %0d want 0", per16); end
        checks++; if (ht16 !== 16'd0)    begin errors++; $display("FAIL midreset_high_time: got %0d want 0", ht16); end
        @(negedge clk);
        rst = 1'b0;
        n1 = v16_n;
        pulse16(1'b0, 4);
        pulse16(1'b1, 3);
        pulse16(1'b0, 5);
        checks++; if (v16_n !== n1) begin errors++; $display("FAIL midreset_first_rise_valid: got %0d want %0d", v16_n, n1); end
        pulse16(1'b1, 3);
        pulse16(1'b0, 5);
        checks++; if (v16_n !== n1 + 1)  begin errors++; $display("FAIL midreset_second_rise_valid: got %0d want %0d", v16_n, n1 + 1); end
        checks++; if (v16_per !== 16'd8) begin errors++; $display("FAIL midreset_period_after: got %0d want 8", v16_per); end
        checks++; if (v16_ht !== 16'd3)  begin errors++; $display("FAIL midreset_high_after: got %0d want 3", v16_ht); end
    endtask

    task automatic test_loopback(input int cmp);
        int n0;
        n0 = v16_n;
        gen16(cmp, 4);
        checks++; if (v16_n - n0 !== 4) begin errors++; $display("FAIL loop%0d_count: got %0d want 4", cmp, v16_n - n0); end
        checks++; if (v16_ht !== 16'(PWM_PERIOD_CLKS - cmp)) begin
            errors++; $display("FAIL loop%0d_high_time: got %0d want %0d", cmp, v16_ht, PWM_PERIOD_CLKS - cmp); end
        checks++; if (v16_per !== 16'(PWM_PERIOD_CLKS)) begin
            errors++; $display("FAIL loop%0d_period: got %0d want %0d", cmp, v16_per, PWM_PERIOD_CLKS); end
        checks++; if (v16_gap !== PWM_PERIOD_CLKS) begin
            errors++; $display("FAIL loop%0d_valid_gap: got %0d want %0d", cmp, v16_gap, PWM_PERIOD_CLKS); end
        checks++; if (locked16 !== 1'b1) begin errors++; $display("FAIL loop%0d_locked: got %0b want 1", cmp, locked16); end
    endtask

    task automatic test_stuck();
        for (int p = 0; p < 3; p++) begin
            pulse8(1'b1, 3);
            pulse8(1'b0, 5);
        end
        pulse8(1'b1, 10);
        checks++; if (locked8 !== 1'b1) begin errors++; $display("FAIL stuck_pre_locked: got %0b want 1", locked8); end
        checks++; if (lvl8 !== 1'b1)    begin errors++; $display("FAIL stuck_level: got %0b want 1", lvl8); end
        pulse8(1'b1, 240);
        checks++; if (stuck8 !== 1'b0)  begin errors++; $display("FAIL stuck_early: got %0b want 0", stuck8); end
        pulse8(1'b1, 20);
        checks++; if (stuck8 !== 1'b1)  begin errors++; $display("FAIL stuck_set: got %0b want 1", stuck8); end
        checks++; if (locked8 !== 1'b0) begin errors++; $display("FAIL stuck_locked_drop: got %0b want 0", locked8); end
        pulse8(1'b0, 6);
        checks++; if (stuck8 !== 1'b0)  begin errors++; $display("FAIL stuck_clear: got %0b want 0", stuck8); end
        checks++; if (locked8 !== 1'b0) begin errors++; $display("FAIL stuck_relock: got %0b want 0", locked8); end
    endtask

    task automatic test_max_edge();
        int n0;
        n0 = v8_n;
        pulse8(1'b1, 100);
        pulse8(1'b0, 155);
        pulse8(1'b1, 8);
        checks++; if (v8_n !== n0 + 1)  begin errors++; $display("FAIL maxedge_count: got %0d want %0d", v8_n, n0 + 1); end
        checks++; if (v8_per !== 8'd255) begin errors++; $display("FAIL maxedge_period: got %0d want 255", v8_per); end
        checks++; if (v8_ht !== 8'd100)  begin errors++; $display("FAIL maxedge_high_time: got %0d want 100", v8_ht); end
        checks++; if (stuck8 !== 1'b0)   begin errors++; $display("FAIL maxedge_stuck: got %0b want 0", stuck8); end
        checks++; if (locked8 !== 1'b1)  begin errors++; $display("FAIL maxedge_locked: got %0b want 1", locked8); end
        pulse8(1'b0, 10);
    endtask

    task automatic test_enable();
        int n0;
        pulse16(1'b0, 5);
        for (int p = 0; p < 3; p++) begin
            pulse16(1'b1, 3);
            pulse16(1'b0, 5);
        end
        pulse16(1'b1, 6);
        en16 = 1'b0;
        pulse16(1'b1, 2);
        checks++; if (locked16 !== 1'b0) begin errors++; $display("FAIL disable_locked: got %0b want 0", locked16); end
        checks++; if (valid16 !== 1'b0)  begin errors++; $display("FAIL disable_valid: got %0b want 0", valid16); end
        checks++; if (stuck16 !== 1'b0)  begin errors++; $display("FAIL disable_stuck: got %0b want 0", stuck16); end
        checks++; if (per16 !== 16'd8)   begin errors++; $display("FAIL disable_period_hold: got %0d want 8", per16); end
        checks++; if (ht16 !== 16'd3)    begin errors++; $display("FAIL disable_high_hold: got %0d want 3", ht16); end
        checks++; if (lvl16 !== 1'b1)    begin errors++; $display("FAIL disable_level: got %0b want 1", lvl16); end
        n0 = v16_n;
        pulse16(1'b1, 4);
        pulse16(1'b0, 5);
        en16 = 1'b1;
        pulse16(1'b0, 5);
        pulse16(1'b1, 3);
        pulse16(1'b0, 5);
        checks++; if (v16_n !== n0) begin errors++; $display("FAIL reenable_early_valid: got %0d want %0d", v16_n, n0); end
        pulse16(1'b1, 3);
        pulse16(1'b0, 5);
        checks++; if (v16_n !== n0 + 1)  begin errors++; $display("FAIL reenable_valid: got %0d want %0d", v16_n, n0 + 1); end
        checks++; if (v16_ht !== 16'd3)  begin errors++; $display("FAIL reenable_high_time: got %0d want 3", v16_ht); end
        checks++; if (v16_per !== 16'd8) begin errors++; $display("FAIL reenable_period: got %0d want 8", v16_per); end
        checks++; if (locked16 !== 1'b1) begin errors++; $display("FAIL reenable_locked: got %0b want 1", locked16); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_square();
        test_midstream_reset();
        test_loopback(64);
        test_loopback(128);
        test_loopback(200);
        test_stuck();
        test_max_edge();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
